// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one single-port image BRAM between the image
// loader (requester 0) and the edge-detection engine (requester 1).
//
// Handshake (valid/ready): a requester raises req with we/addr/wdata stable
// and holds them until the cycle in which its gnt is 1. The access is issued
// to the BRAM in that same cycle. Dropping req before gnt cancels the request.
//
// Arbitration is round-robin on contention, with a lock that lets the owner
// keep the port across a burst (e.g. a 3x3 neighbourhood fetch). Reads are
// tracked by a tag pipeline RD_LATENCY deep, so read data returns to the right
// owner with an rvalid strobe. RD_LATENCY must be 1 or 2.
//
// Optional feature: define BRAM_ARB_PERF_EN to add saturating grant/stall
// counters with a synchronous clear input.
module bram_port_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  input  logic [DATA_W-1:0] bram_douta,
  output logic              busy,
  output logic [1:0]        dbg_state
`ifdef BRAM_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       perf_gnt0,
  output logic [15:0]       perf_gnt1,
  output logic [15:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_nx;
  // rr = 0: requester 0 wins the next contended cycle; rr = 1: requester 1
  logic rr, rr_nx;

  logic rd_issue;
  logic [RD_LATENCY-1:0] tag_v;
  logic [RD_LATENCY-1:0] tag_o;

  assign dbg_state = state;

  // State register: FSM state and round-robin pointer
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_nx;
      rr    <= rr_nx;
    end
  end

  // Next-state logic: lock entry/exit and pointer update
  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    case (state)
      IDLE: begin
        if (m0_gnt) begin
          if (m1_req) rr_nx = 1'b1;
          if (m0_lock) state_nx = OWN0;
        end else if (m1_gnt) begin
          if (m0_req) rr_nx = 1'b0;
          if (m1_lock) state_nx = OWN1;
        end
      end
      // Exit on an unlocked grant or when the owner drops req; either way the
      // other requester gets the next contended cycle.
      OWN0: begin
        if (!m0_req || !m0_lock) begin
          state_nx = IDLE;
          rr_nx    = 1'b1;
        end
      end
      OWN1: begin
        if (!m1_req || !m1_lock) begin
          state_nx = IDLE;
          rr_nx    = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: grants from current req and state
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req && (!m1_req || !rr)) m0_gnt = 1'b1;
        else if (m1_req)                m1_gnt = 1'b1;
      end
      OWN0:    m0_gnt = m0_req;
      OWN1:    m1_gnt = m1_req;
      default: ;
    endcase
  end

  // BRAM drive: mux the granted requester, all zero when nobody is granted
  always_comb begin
    bram_ena   = m0_gnt | m1_gnt;
    bram_wea   = 1'b0;
    bram_addra = '0;
    bram_dina  = '0;
    if (m0_gnt) begin
      bram_wea   = m0_we;
      bram_addra = m0_addr;
      bram_dina  = m0_wdata;
    end else if (m1_gnt) begin
      bram_wea   = m1_we;
      bram_addra = m1_addr;
      bram_dina  = m1_wdata;
    end
  end

  assign rd_issue = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

  // Read-tag pipeline: one {valid, owner} entry per cycle of BRAM latency
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v[0] <= rd_issue;
      tag_o[0] <= m1_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  // Read data passes straight through from the BRAM, gated by rvalid
  assign m0_rvalid = tag_v[RD_LATENCY-1] & ~tag_o[RD_LATENCY-1];
  assign m1_rvalid = tag_v[RD_LATENCY-1] &  tag_o[RD_LATENCY-1];
  assign m0_rdata  = m0_rvalid ? bram_douta : '0;
  assign m1_rdata  = m1_rvalid ? bram_douta : '0;
  assign busy      = bram_ena | (|tag_v);

`ifdef BRAM_ARB_PERF_EN
  logic stall;
  assign stall = (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt);

  // Saturating performance counters; perf_clr wins over increment
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      perf_gnt0  <= '0;
      perf_gnt1  <= '0;
      perf_stall <= '0;
    end else if (perf_clr) begin
      perf_gnt0  <= '0;
      perf_gnt1  <= '0;
      perf_stall <= '0;
    end else begin
      if (m0_gnt && perf_gnt0 != 16'hFFFF)  perf_gnt0  <= perf_gnt0 + 16'd1;
      if (m1_gnt && perf_gnt1 != 16'hFFFF)  perf_gnt1  <= perf_gnt1 + 16'd1;
      if (stall && perf_stall != 16'hFFFF)  perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter. u_dut uses RD_LATENCY=1, u_dut2 uses
// RD_LATENCY=2 with only requester 0 active. Each instance has its own BRAM
// model and shadow memory; expected read data and arrival cycle are queued
// when a read is granted and popped when rvalid appears.
module tb_bram_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clka;
  logic rst_n;
  int   cyc;

  initial clka = 1'b0;
  always #5 clka = ~clka;
  initial cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  // ---------------- DUT 1 (latency 1) ----------------
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [12:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        bram_ena, bram_wea, busy;
  logic [12:0] bram_addra;
  logic [7:0]  bram_dina, bram_douta;
  logic [1:0]  dbg_state;
`ifdef BRAM_ARB_PERF_EN
  logic        perf_clr;
  logic [15:0] perf_gnt0, perf_gnt1, perf_stall;
`endif

  bram_port_arbiter #(.ADDR_W(13), .DATA_W(8), .RD_LATENCY(1)) u_dut (
    .clka(clka), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_douta(bram_douta), .busy(busy), .dbg_state(dbg_state)
`ifdef BRAM_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_stall(perf_stall)
`endif
  );

  logic [7:0] mem1 [0:8191];
  always @(posedge clka) begin
    if (bram_ena) begin
      if (bram_wea) mem1[bram_addra] <= bram_dina;
      else          bram_douta <= mem1[bram_addra];
    end
  end

  // ---------------- DUT 2 (latency 2) ----------------
  logic        n0_req, n0_we, n0_lock, n1_req, n1_we, n1_lock;
  logic [12:0] n0_addr, n1_addr;
  logic [7:0]  n0_wdata, n1_wdata;
  logic        n0_gnt, n0_rvalid, n1_gnt, n1_rvalid;
  logic [7:0]  n0_rdata, n1_rdata;
  logic        b2_ena, b2_wea, busy2;
  logic [12:0] b2_addra;
  logic [7:0]  b2_dina, b2_douta, b2_dout_a;
  logic [1:0]  dbg_state2;
`ifdef BRAM_ARB_PERF_EN
  logic        perf_clr2;
  logic [15:0] p2_gnt0, p2_gnt1, p2_stall;
`endif

  bram_port_arbiter #(.ADDR_W(13), .DATA_W(8), .RD_LATENCY(2)) u_dut2 (
    .clka(clka), .rst_n(rst_n),
    .m0_req(n0_req), .m0_we(n0_we), .m0_lock(n0_lock), .m0_addr(n0_addr),
    .m0_wdata(n0_wdata), .m0_gnt(n0_gnt), .m0_rvalid(n0_rvalid), .m0_rdata(n0_rdata),
    .m1_req(n1_req), .m1_we(n1_we), .m1_lock(n1_lock), .m1_addr(n1_addr),
    .m1_wdata(n1_wdata), .m1_gnt(n1_gnt), .m1_rvalid(n1_rvalid), .m1_rdata(n1_rdata),
    .bram_ena(b2_ena), .bram_wea(b2_wea), .bram_addra(b2_addra),
    .bram_dina(b2_dina), .bram_douta(b2_douta), .busy(busy2), .dbg_state(dbg_state2)
`ifdef BRAM_ARB_PERF_EN
    , .perf_clr(perf_clr2), .perf_gnt0(p2_gnt0), .perf_gnt1(p2_gnt1), .perf_stall(p2_stall)
`endif
  );

  logic [7:0] mem2 [0:8191];
  always @(posedge clka) begin
    if (b2_ena) begin
      if (b2_wea) mem2[b2_addra] <= b2_dina;
      else        b2_dout_a <= mem2[b2_addra];
    end
    b2_douta <= b2_dout_a;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [31:0] exp2_q[$];
  logic [7:0]  shadow1 [0:8191];
  logic [7:0]  shadow2 [0:8191];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Return monitors: each rvalid must match the next queued {due_cycle, data}
  always @(negedge clka) begin
    logic [31:0] e;
    if (rst_n) begin
      if (m0_rvalid) begin
        if (exp0_q.size() == 0) check("rv0_spurious", 64'd1, 64'd0);
        else begin
          e = exp0_q.pop_front();
          check("rv0_data", 64'({cyc[23:0], m0_rdata}), 64'(e));
        end
      end else check("rd0_idle_zero", 64'(m0_rdata), 64'd0);
      if (m1_rvalid) begin
        if (exp1_q.size() == 0) check("rv1_spurious", 64'd1, 64'd0);
        else begin
          e = exp1_q.pop_front();
          check("rv1_data", 64'({cyc[23:0], m1_rdata}), 64'(e));
        end
      end else check("rd1_idle_zero", 64'(m1_rdata), 64'd0);
      if (n0_rvalid) begin
        if (exp2_q.size() == 0) check("rv2_spurious", 64'd1, 64'd0);
        else begin
          e = exp2_q.pop_front();
          check("rv2_data", 64'({cyc[23:0], n0_rdata}), 64'(e));
        end
      end
      if (n1_rvalid) check("rv2_m1_spurious", 64'd1, 64'd0);
    end
  end

  // ---------------- driver ----------------
  // who: 0 = u_dut m0, 1 = u_dut m1, 2 = u_dut2 m0. Called just after a
  // rising edge; returns just after the rising edge that ends the grant cycle.
  task automatic drive(input int who, input logic we, input logic [12:0] addr,
                       input logic [7:0] wd, input logic lock);
    bit got;
    int n;
    logic g;
    logic [23:0] due;
    case (who)
      0: begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_lock = lock; end
      1: begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_lock = lock; end
      default: begin n0_req = 1; n0_we = we; n0_addr = addr; n0_wdata = wd; n0_lock = lock; end
    endcase
    got = 0;
    n = 0;
    while (!got && n < 100) begin
      @(negedge clka);
      g = (who == 0) ? m0_gnt : (who == 1) ? m1_gnt : n0_gnt;
      if (g) begin
        got = 1;
        if (who == 2) begin
          due = 24'(cyc) + 24'd2;
          if (we) shadow2[addr] = wd;
          else    exp2_q.push_back({due, shadow2[addr]});
        end else begin
          due = 24'(cyc) + 24'd1;
          if (we) shadow1[addr] = wd;
          else if (who == 0) exp0_q.push_back({due, shadow1[addr]});
          else               exp1_q.push_back({due, shadow1[addr]});
        end
      end
      n++;
      @(posedge clka);
      #1;
    end
    if (!got) check("grant_timeout", 64'd0, 64'd1);
    case (who)
      0: begin m0_req = 0; m0_lock = 0; end
      1: begin m1_req = 0; m1_lock = 0; end
      default: begin n0_req = 0; n0_lock = 0; end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 0;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    n0_req = 0; n0_we = 0; n0_lock = 0; n0_addr = '0; n0_wdata = '0;
    n1_req = 0; n1_we = 0; n1_lock = 0; n1_addr = '0; n1_wdata = '0;
`ifdef BRAM_ARB_PERF_EN
    perf_clr = 0; perf_clr2 = 0;
`endif

    // Reset state
    repeat (2) @(negedge clka);
    check("reset_outs", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_ena, bram_wea, busy,
                             m0_rdata, m1_rdata, bram_addra, bram_dina}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_outs2", 64'({n0_gnt, n0_rvalid, busy2, n0_rdata}), 64'd0);
`ifdef BRAM_ARB_PERF_EN
    check("reset_perf", 64'({perf_gnt0, perf_gnt1, perf_stall}), 64'd0);
`endif
    @(posedge clka); #1;
    rst_n = 1;
    @(posedge clka); #1;

    // Single writer: grant and BRAM drive in the same cycle
    m0_req = 1; m0_we = 1; m0_addr = 13'h0005; m0_wdata = 8'hA5;
    @(negedge clka);
    check("w_gnt", 64'({m0_gnt, m1_gnt}), 64'h2);
    check("w_bram", 64'({bram_ena, bram_wea, bram_addra, bram_dina}), 64'({2'b11, 13'h0005, 8'hA5}));
    check("w_busy", 64'(busy), 64'd1);
    shadow1[13'h0005] = 8'hA5;
    @(posedge clka); #1;
    m0_req = 0;
    drive(0, 0, 13'h0005, 8'h00, 0);
    // rvalid cycle: BRAM idle, read still in the pipeline
    @(negedge clka);
    check("idle_bram", 64'({bram_ena, bram_wea, bram_addra, bram_dina}), 64'd0);
    check("busy_inflight", 64'(busy), 64'd1);
    check("rv_after_read", 64'(m0_rvalid), 64'd1);
    @(posedge clka); #1;

    // Preload 0x0000..0x0008 with random pixels
    for (int i = 0; i < 9; i++) drive(0, 1, 13'(i), 8'($urandom_range(0, 255)), 0);

    // Contention: both read continuously, grants alternate starting at m0
    fork
      begin for (int i = 0; i < 4; i++) drive(0, 0, 13'(i), 8'h00, 0); end
      begin for (int j = 0; j < 4; j++) drive(1, 0, 13'(j + 4), 8'h00, 0); end
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clka);
          check("cont_gnt", 64'({m1_gnt, m0_gnt}), (k % 2 == 1) ? 64'h2 : 64'h1);
        end
      end
    join
    repeat (2) @(posedge clka); #1;

    // Lock burst: 9 m1 reads locked, m0 write waits until the cycle after
    fork
      begin for (int i = 0; i < 9; i++) drive(1, 0, 13'(i), 8'h00, (i < 8) ? 1'b1 : 1'b0); end
      begin @(posedge clka); #1; drive(0, 1, 13'h0020, 8'h5C, 0); end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clka);
          check("lock_gnt", 64'({m1_gnt, m0_gnt}), (k < 9) ? 64'h2 : 64'h1);
        end
      end
    join
    // Read-after-write on consecutive grants
    drive(0, 0, 13'h0020, 8'h00, 0);
    repeat (3) @(posedge clka); #1;

    // Reset mid-read: the granted read must never return
    m0_req = 1; m0_we = 0; m0_addr = 13'h0003;
    @(negedge clka);
    check("rst_rd_gnt", 64'(m0_gnt), 64'd1);
    m0_req = 0;
    #1 rst_n = 0;
    #1;
    check("rst_async_outs", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_ena, bram_wea, busy,
                                 m0_rdata, m1_rdata, dbg_state}), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clka);
      check("rst_no_rvalid", 64'({m0_rvalid, m1_rvalid, busy}), 64'd0);
    end
    @(posedge clka); #1;
    rst_n = 1;
    @(posedge clka); #1;
    fork
      drive(0, 0, 13'h0001, 8'h00, 0);
      drive(1, 0, 13'h0002, 8'h00, 0);
      begin @(negedge clka); check("post_rst_rr", 64'({m1_gnt, m0_gnt}), 64'h1); end
    join
    repeat (3) @(posedge clka); #1;

    // Latency 2: back-to-back reads of 0x1FFF and 0x0000
    drive(2, 1, 13'h1FFF, 8'h3C, 0);
    drive(2, 1, 13'h0000, 8'hC3, 0);
    repeat (2) @(posedge clka); #1;
    fork
      begin drive(2, 0, 13'h1FFF, 8'h00, 0); drive(2, 0, 13'h0000, 8'h00, 0); end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clka);
          check("lat2_busy", 64'(busy2), (k < 4) ? 64'd1 : 64'd0);
        end
      end
    join
    repeat (2) @(posedge clka); #1;

`ifdef BRAM_ARB_PERF_EN
    // Perf: clear, then 10 contended write cycles
    perf_clr = 1;
    @(posedge clka); #1;
    perf_clr = 0;
    @(negedge clka);
    check("perf_clr0", 64'({perf_gnt0, perf_gnt1, perf_stall}), 64'd0);
    @(posedge clka); #1;
    m0_req = 1; m0_we = 1; m0_addr = 13'h0100; m0_wdata = 8'h11;
    m1_req = 1; m1_we = 1; m1_addr = 13'h0101; m1_wdata = 8'h22;
    repeat (10) @(posedge clka);
    #1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    @(negedge clka);
    check("perf_gnt0", 64'(perf_gnt0), 64'd5);
    check("perf_gnt1", 64'(perf_gnt1), 64'd5);
    check("perf_stall", 64'(perf_stall), 64'd10);
    @(posedge clka); #1;
    perf_clr = 1;
    @(posedge clka); #1;
    perf_clr = 0;
    @(negedge clka);
    check("perf_clr1", 64'({perf_gnt0, perf_gnt1, perf_stall}), 64'd0);
    @(posedge clka); #1;
`endif

    repeat (4) @(negedge clka);
    check("q0_empty", 64'(exp0_q.size()), 64'd0);
    check("q1_empty", 64'(exp1_q.size()), 64'd0);
    check("q2_empty", 64'(exp2_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
